// File: rtl/mul_iterative_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_iterative_unit_pkg
// Shared decode constants, FSM state encoding and small decode helpers for the
// iterative RV32M/RV64M multiply unit.
// -----------------------------------------------------------------------------
package mul_iterative_unit_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] FUNCT3_MULHU  = 3'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Multiply group of OP-class M-extension instructions; funct3[2]=1 is
    // the divide group and is left for another unit.
    function automatic logic is_mul_op(input logic [6:0] opcode,
                                       input logic [6:0] funct7,
                                       input logic [2:0] funct3);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && !funct3[2];
    endfunction

    // MUL keeps both operands unsigned: the low half of the product does not
    // depend on signedness.
    function automatic logic rs1_is_signed(input logic [2:0] funct3);
        return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] funct3);
        return funct3 == FUNCT3_MULH;
    endfunction

endpackage

// File: rtl/mul_iterative_unit_step.sv
// -----------------------------------------------------------------------------
// mul_partial_step
// One shift-add step: acc_next = acc + ((mag1 * chunk) << offset).
// Ports:
//   acc      in  2*XLEN   running accumulator
//   mag1     in  XLEN     multiplicand magnitude
//   chunk    in  BPC      current multiplier digit (BITS_PER_CYCLE bits)
//   offset   in  OFF_W    bit position of this digit
//   acc_next out 2*XLEN   updated accumulator
// -----------------------------------------------------------------------------
module mul_partial_step
    import mul_iterative_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int OFF_W          = $clog2(XLEN)
) (
    input  logic [2*XLEN-1:0]         acc,
    input  logic [XLEN-1:0]           mag1,
    input  logic [BITS_PER_CYCLE-1:0] chunk,
    input  logic [OFF_W-1:0]          offset,
    output logic [2*XLEN-1:0]         acc_next
);

    logic [2*XLEN-1:0] partial;

    // NOTE: every variable written in a combinational block gets a value on
    // every path, otherwise synthesis infers a latch.
    always_comb begin
        partial  = {{XLEN{1'b0}}, mag1} * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, chunk};
        acc_next = acc + (partial << offset);
    end

endmodule

// File: rtl/mul_iterative_unit.sv
// -----------------------------------------------------------------------------
// mul_iterative_unit
// Multi-cycle MUL/MULH/MULHSU/MULHU unit. Operands are reduced to magnitudes
// at accept, multiplied by shift-add over BITS_PER_CYCLE bits of rs2 per
// clock, and the sign is re-applied to the 2*XLEN product at the end.
// Ports:
//   clk             in   clock
//   reset           in   synchronous active-high reset
//   opcode/funct7/funct3  in  instruction decode fields
//   accuracy_level  in   operand LSBs to zero (APPROXIMATE=1 only)
//   bus_rs1/bus_rs2 in   source operands
//   mul_unit_busy   out  pipeline stall request (combinational)
//   mul_valid       out  one-cycle completion pulse
//   mul_output      out  result register, held until the next completion
// -----------------------------------------------------------------------------
module mul_iterative_unit
    import mul_iterative_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int APPROXIMATE    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [7:0]      accuracy_level,
    input  logic [XLEN-1:0] bus_rs1,
    input  logic [XLEN-1:0] bus_rs2,
    output logic            mul_unit_busy,
    output logic            mul_valid,
    output logic [XLEN-1:0] mul_output
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int OFF_W = $clog2(XLEN);

    state_t state, state_next;

    logic                 match;
    logic                 last_iter;
    logic [CNT_W-1:0]     iter_cnt;
    logic [OFF_W-1:0]     offset_q;
    logic                 low_half_q;
    logic                 neg_q;
    logic [XLEN-1:0]      mag1_q, mag2_q;
    logic [2*XLEN-1:0]    acc_q, acc_next, product;

    logic                 sign1, sign2;
    logic [XLEN-1:0]      trunc_mask, mag1_in, mag2_in;

    assign match     = is_mul_op(opcode, funct7, funct3);
    assign last_iter = (iter_cnt == CNT_W'(1));

    // ---------------- FSM ----------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        mul_unit_busy = 1'b0;
        mul_valid     = 1'b0;
        case (state)
            IDLE: begin
                mul_unit_busy = match;
                if (match) state_next = COMPUTE;
            end
            COMPUTE: begin
                mul_unit_busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                mul_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Operand preparation at accept ----------------
    always_comb begin
        sign1 = rs1_is_signed(funct3) && bus_rs1[XLEN-1];
        sign2 = rs2_is_signed(funct3) && bus_rs2[XLEN-1];
        // Bit i survives unless it lies below accuracy_level; levels above
        // XLEN simply clear the whole magnitude.
        for (int i = 0; i < XLEN; i++) begin
            trunc_mask[i] = (APPROXIMATE == 0) || (i >= int'(accuracy_level));
        end
        // -x of the most negative value wraps back to 2^(XLEN-1), which is
        // exactly its magnitude when read as unsigned.
        mag1_in = (sign1 ? -bus_rs1 : bus_rs1) & trunc_mask;
        mag2_in = (sign2 ? -bus_rs2 : bus_rs2) & trunc_mask;
    end

    // ---------------- Shift-add datapath ----------------
    mul_partial_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .OFF_W          (OFF_W)
    ) u_step (
        .acc      (acc_q),
        .mag1     (mag1_q),
        .chunk    (mag2_q[BITS_PER_CYCLE-1:0]),
        .offset   (offset_q),
        .acc_next (acc_next)
    );

    assign product = neg_q ? -acc_next : acc_next;

    // NOTE: the datapath registers are cleared by reset too, so an aborted
    // operation leaves no residue and mul_output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_cnt   <= '0;
            offset_q   <= '0;
            low_half_q <= 1'b0;
            neg_q      <= 1'b0;
            mag1_q     <= '0;
            mag2_q     <= '0;
            acc_q      <= '0;
            mul_output <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        low_half_q <= (funct3 == FUNCT3_MUL);
                        neg_q      <= sign1 ^ sign2;
                        mag1_q     <= mag1_in;
                        mag2_q     <= mag2_in;
                        acc_q      <= '0;
                        offset_q   <= '0;
                        iter_cnt   <= CNT_W'(N);
                    end
                end
                COMPUTE: begin
                    acc_q    <= acc_next;
                    mag2_q   <= mag2_q >> BITS_PER_CYCLE;
                    offset_q <= offset_q + OFF_W'(BITS_PER_CYCLE);
                    iter_cnt <= iter_cnt - CNT_W'(1);
                    // The final product is registered on the edge that enters
                    // DONE, so mul_output is already valid alongside mul_valid.
                    if (last_iter) begin
                        mul_output <= low_half_q ? product[XLEN-1:0]
                                                 : product[2*XLEN-1:XLEN];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iterative_unit.sv
module tb_mul_iterative_unit;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] F7M = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // index 0: defaults, 1: APPROXIMATE=1, 2: XLEN=64 BITS_PER_CYCLE=1
    logic        rst   [3];
    logic [6:0]  opc   [3];
    logic [6:0]  f7    [3];
    logic [2:0]  f3    [3];
    logic [7:0]  accl  [3];
    logic [63:0] rs1   [3];
    logic [63:0] rs2   [3];
    logic        busy  [3];
    logic        valid [3];
    logic [31:0] out0, out1;
    logic [63:0] out2;

    mul_iterative_unit dut0 (
        .clk(clk), .reset(rst[0]), .opcode(opc[0]), .funct7(f7[0]), .funct3(f3[0]),
        .accuracy_level(accl[0]), .bus_rs1(rs1[0][31:0]), .bus_rs2(rs2[0][31:0]),
        .mul_unit_busy(busy[0]), .mul_valid(valid[0]), .mul_output(out0));

    mul_iterative_unit #(.APPROXIMATE(1)) dut1 (
        .clk(clk), .reset(rst[1]), .opcode(opc[1]), .funct7(f7[1]), .funct3(f3[1]),
        .accuracy_level(accl[1]), .bus_rs1(rs1[1][31:0]), .bus_rs2(rs2[1][31:0]),
        .mul_unit_busy(busy[1]), .mul_valid(valid[1]), .mul_output(out1));

    mul_iterative_unit #(.XLEN(64), .BITS_PER_CYCLE(1)) dut2 (
        .clk(clk), .reset(rst[2]), .opcode(opc[2]), .funct7(f7[2]), .funct3(f3[2]),
        .accuracy_level(accl[2]), .bus_rs1(rs1[2]), .bus_rs2(rs2[2]),
        .mul_unit_busy(busy[2]), .mul_valid(valid[2]), .mul_output(out2));

    function automatic logic [63:0] get_out(input int d);
        case (d)
            0:       return {32'b0, out0};
            1:       return {32'b0, out1};
            default: return out2;
        endcase
    endfunction

    function automatic int n_iter(input int d);
        return (d == 2) ? 64 : 8;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [127:0] widen(input logic [63:0] v, input int xl, input bit s);
        if (xl == 32) return s ? {{96{v[31]}}, v[31:0]} : {96'b0, v[31:0]};
        return s ? {{64{v[63]}}, v} : {64'b0, v};
    endfunction

    function automatic logic [127:0] approx(input logic [127:0] v, input logic [7:0] al, input int xl);
        int          k;
        bit          neg;
        logic [127:0] m;
        k   = (int'(al) > xl) ? xl : int'(al);
        neg = v[127];
        m   = neg ? -v : v;
        m   = (m >> k) << k;
        return neg ? -m : m;
    endfunction

    function automatic logic [63:0] ref_mul(input int d, input logic [2:0] fn,
                                            input logic [63:0] a_in, input logic [63:0] b_in,
                                            input logic [7:0] al);
        int           xl;
        logic [127:0] a, b, p;
        xl = (d == 2) ? 64 : 32;
        a  = widen(a_in, xl, (fn == 3'd1) || (fn == 3'd2));
        b  = widen(b_in, xl, (fn == 3'd1));
        if (d == 1) begin
            a = approx(a, al, xl);
            b = approx(b, al, xl);
        end
        p = a * b;
        if (fn == 3'd0) return (xl == 32) ? {32'b0, p[31:0]} : p[63:0];
        return (xl == 32) ? {32'b0, p[63:32]} : p[127:64];
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [63:0] val, input int c);
        exp_t e;
        e.val = val;
        e.cyc = c;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_check(input int d);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_valid dut%0d: got valid with output 0x%0h, required no valid", d, get_out(d));
        end else begin
            check($sformatf("result dut%0d", d), get_out(d), e.val);
            check($sformatf("latency dut%0d", d), 64'(cyc), 64'(e.cyc + n_iter(d) + 1));
            check($sformatf("busy_in_done dut%0d", d), {63'b0, busy[d]}, 64'd0);
        end
    endtask

    always @(negedge clk) if (valid[0] === 1'b1) pop_check(0);
    always @(negedge clk) if (valid[1] === 1'b1) pop_check(1);
    always @(negedge clk) if (valid[2] === 1'b1) pop_check(2);

    // ---------------- stimulus helpers ----------------
    task automatic deassert(input int d);
        opc[d]  = 7'd0;
        f7[d]   = 7'd0;
        f3[d]   = 3'($urandom);
        accl[d] = 8'($urandom);
        rs1[d]  = {$urandom, $urandom};
        rs2[d]  = {$urandom, $urandom};
    endtask

    task automatic drive(input int d, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] al);
        opc[d]  = OP;
        f7[d]   = F7M;
        f3[d]   = fn;
        accl[d] = al;
        rs1[d]  = a;
        rs2[d]  = b;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((busy[d] !== 1'b0 || valid[d] !== 1'b0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout dut%0d: got busy=%0b valid=%0b, required idle within 400 cycles",
                     d, busy[d], valid[d]);
        end
    endtask

    // Issue one operation; operands are scrambled right after the accept edge.
    task automatic issue(input int d, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] al, input logic [63:0] exp);
        wait_idle(d);
        drive(d, fn, a, b, al);
        push(d, exp, cyc);
        #1;
        check($sformatf("busy_at_accept dut%0d", d), {63'b0, busy[d]}, 64'd1);
        @(posedge clk); #1;
        deassert(d);
    endtask

    function automatic logic [63:0] pick(input int d);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = (d == 2) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            3:       v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return (d == 2) ? v : {32'b0, v[31:0]};
    endfunction

    task automatic issue_random(input int d);
        logic [2:0]  fn;
        logic [63:0] a, b;
        logic [7:0]  al;
        fn = 3'($urandom_range(0, 3));
        a  = pick(d);
        b  = pick(d);
        al = 8'($urandom_range(0, 40));
        issue(d, fn, a, b, al, ref_mul(d, fn, a, b, al));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            deassert(i);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy dut%0d", i),  {63'b0, busy[i]},  64'd0);
            check($sformatf("reset_valid dut%0d", i), {63'b0, valid[i]}, 64'd0);
            check($sformatf("reset_out dut%0d", i),   get_out(i),        64'd0);
            rst[i] = 1'b0;
        end
        @(posedge clk); #1;

        // MUL 10*20 with the stall profile checked cycle by cycle
        wait_idle(0);
        drive(0, 3'd0, 64'd10, 64'd20, 8'd0);
        push(0, 64'd200, cyc);
        #1;
        check("busy_cycle0", {63'b0, busy[0]}, 64'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) deassert(0);
            check($sformatf("busy_cycle%0d", i), {63'b0, busy[0]}, 64'd1);
        end
        @(posedge clk); #1;
        check("busy_cycle9", {63'b0, busy[0]}, 64'd0);
        check("valid_cycle9", {63'b0, valid[0]}, 64'd1);

        // directed corner cases
        issue(0, 3'd1, 64'hFFFF_FFFE, 64'd3,         8'd0, 64'hFFFF_FFFF);
        issue(0, 3'd0, 64'hFFFF_FFFE, 64'd3,         8'd0, 64'hFFFF_FFFA);
        issue(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 8'd0, 64'hFFFF_FFFF);
        issue(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 8'd0, 64'hFFFF_FFFE);
        issue(0, 3'd1, 64'h8000_0000, 64'hFFFF_FFFF, 8'd0, 64'h0);
        issue(0, 3'd0, 64'h8000_0000, 64'hFFFF_FFFF, 8'd0, 64'h8000_0000);
        issue(0, 3'd0, 64'd10,        64'd20,        8'd2, 64'd200);
        issue(0, 3'd1, 64'd0,         64'hDEAD_BEEF, 8'd0, 64'd0);
        issue(1, 3'd0, 64'd10,        64'd20,        8'd2, 64'd160);
        issue(1, 3'd0, 64'd10,        64'd20,        8'd0, 64'd200);
        issue(2, 3'd3, '1,            64'd2,         8'd0, 64'd1);

        // back-to-back: match held through DONE; operands change mid-COMPUTE
        begin
            logic [63:0] a, b, c, e;
            logic [2:0]  fa, fc;
            int          k;
            wait_idle(0);
            fa = 3'($urandom_range(0, 3));
            fc = 3'($urandom_range(0, 3));
            a = pick(0); b = pick(0); c = pick(0); e = pick(0);
            drive(0, fa, a, b, 8'd0);
            k = cyc;
            push(0, ref_mul(0, fa, a, b, 8'd0), k);
            repeat (2) @(posedge clk);
            #1;
            drive(0, fc, c, e, 8'd0);
            push(0, ref_mul(0, fc, c, e, 8'd0), k + 10);
            repeat (9) @(posedge clk);
            #1;
            deassert(0);
        end

        // divide group is not claimed
        for (int f = 4; f < 8; f++) begin
            wait_idle(0);
            drive(0, 3'(f), 64'd100, 64'd7, 8'd0);
            for (int i = 0; i < 3; i++) begin
                #1;
                check($sformatf("div_busy f3=%0d", f), {63'b0, busy[0]}, 64'd0);
                @(posedge clk); #1;
            end
            deassert(0);
        end

        // randomized traffic
        for (int i = 0; i < 30; i++) issue_random(0);
        for (int i = 0; i < 20; i++) issue_random(1);
        for (int i = 0; i < 6;  i++) issue_random(2);

        // reset mid-operation aborts with no valid pulse
        issue(0, 3'd0, 64'd3, 64'd5, 8'd0, 64'd15);
        wait_idle(0);
        drive(0, 3'd0, 64'd7, 64'd9, 8'd0);
        @(posedge clk); #1;
        deassert(0);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",  {63'b0, busy[0]},  64'd0);
        check("abort_valid", {63'b0, valid[0]}, 64'd0);
        check("abort_out",   get_out(0),        64'd0);
        rst[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_out_hold", get_out(0), 64'd0);

        // drain
        begin
            int n;
            n = 0;
            while ((q0.size() + q1.size() + q2.size()) > 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        if ((q0.size() + q1.size() + q2.size()) > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_results: got %0d outstanding, required 0",
                     q0.size() + q1.size() + q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_iterative_unit.md
Name: mul_iterative_unit

Overview:
Multi-cycle RV32M/RV64M multiply unit. It executes MUL, MULH, MULHSU and MULHU as an iterative shift-add over BITS_PER_CYCLE operand bits per clock, and has an optional approximate mode that truncates operand LSBs. It is the parametrised, sequential successor to the combinational Multiplier_Unit and sits in the execute stage. While mul_unit_busy is high, the pipeline stalls.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
BITS_PER_CYCLE, 4, rs2 bits consumed per compute cycle; must divide XLEN; legal values 1, 2, 4, 8.
APPROXIMATE, 0, 1 enables operand truncation driven by accuracy_level.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
opcode  input  7  instruction opcode.
funct7  input  7  instruction funct7.
funct3  input  3  instruction funct3.
accuracy_level  input  8  number of operand LSBs to zero; used only when APPROXIMATE=1.
bus_rs1  input  XLEN  source operand 1.
bus_rs2  input  XLEN  source operand 2.
mul_unit_busy  output  1  stall request to the pipeline.
mul_valid  output  1  one-cycle pulse; mul_output is valid for the completed operation.
mul_output  output  XLEN  result register.

Behaviour:
- Reset: state=IDLE; mul_valid=0; mul_output=0; mul_unit_busy=0; all internal registers cleared. Reset mid-operation aborts the operation with no valid pulse.
- Decode match: opcode==7'b0110011 && funct7==7'b0000001 && funct3[2]==0. funct3=4..7 (division) is not matched, so busy stays 0.
- States:
  - IDLE -> COMPUTE on match.
  - COMPUTE runs N = XLEN/BITS_PER_CYCLE cycles, then -> DONE.
  - DONE -> IDLE unconditionally after 1 cycle.
- mul_unit_busy = (IDLE && match) || COMPUTE. It is combinational, so the stall begins in the accept cycle. It is 0 in DONE.
- Accept edge latches funct3, both operands and accuracy_level. Input changes during COMPUTE are ignored.
- Operand preparation at accept:
  - Signedness: rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only. MUL uses both as unsigned, since the low half is identical.
  - Each operand is converted to its magnitude, and a sign flag is recorded.
- Approximate mode: if APPROXIMATE=1, the low min(accuracy_level, XLEN) bits of each magnitude are zeroed. If APPROXIMATE=0, accuracy_level is ignored.
- Each COMPUTE cycle:
  - Add (mag1 * rs2 chunk) << offset into a 2*XLEN accumulator; the chunk is the low BITS_PER_CYCLE bits of mag2.
  - Shift mag2 right by BITS_PER_CYCLE.
  - Decrement the iteration counter.
- Arithmetic width: accumulator is 2*XLEN wide; the magnitude product never overflows it.
- DONE:
  - Product = sign_differs ? -acc : acc, in two's complement over 2*XLEN.
  - mul_output <= MUL ? product[XLEN-1:0] : product[2XLEN-1:XLEN].
  - mul_valid=1 for exactly this cycle.
- Latency: accept in cycle 0; result and mul_valid in cycle N+1. With defaults, N=8 and the result arrives in cycle 9. With BITS_PER_CYCLE=1, the result arrives in cycle 33.
- mul_output holds its value until the next DONE cycle.
- Back-to-back: if a match is still present in the IDLE cycle after DONE, a new operation starts there. The pipeline must retire the instruction in the DONE cycle.
- Corner cases:
  - Most-negative operand magnitude (0x80000000) is representable as an unsigned XLEN magnitude.
  - A zero operand still takes the full N cycles; there is no early termination.

Decomposition:
- Shared package holds:
  - OPCODE_OP = 7'b0110011.
  - FUNCT7_MULDIV = 7'b0000001.
  - FUNCT3_MUL/MULH/MULHSU/MULHU = 0/1/2/3.
  - State encodings IDLE/COMPUTE/DONE.
- One natural sub-module: mul_partial_step. It is combinational and takes acc, mag1, chunk and offset, producing next acc. It is reused across BITS_PER_CYCLE variants.

Test Plan:
- MUL, rs1=10, rs2=20, defaults -> busy high in cycles 0-8; mul_valid in cycle 9 with mul_output=200; busy=0 in cycle 9.
- MULH, rs1=0xFFFFFFFE (-2), rs2=3 -> mul_output=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFFA.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MULH, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x00000000, and the low half is 0x80000000.
- APPROXIMATE=1, accuracy_level=2, MUL 10*20 -> 160. accuracy_level=0 -> 200. APPROXIMATE=0 with accuracy_level=2 -> 200.
- funct3=4 (DIV) presented -> busy=0 and mul_valid never asserts. Reset asserted in cycle 4 of a MUL -> IDLE next cycle, mul_output=0, no valid pulse.
- BITS_PER_CYCLE=1 and XLEN=64, MULHU 0xFFFF...F * 2 -> mul_valid in cycle 65, mul_output=1. Operands changed during COMPUTE do not affect the result.
